// File: rtl/wb_req_bridge.sv
// wb_req_bridge: Wishbone classic slave that turns each strobe into a single-beat
// request on a valid/ready request channel, with a one-beat write path and a
// one-beat read return path. Reads that never return can be abandoned after a
// configurable number of wait cycles. All outputs are registered.

module wb_req_bridge #(
    parameter logic [31:0] BASE    = 32'h0000_0000,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // Wishbone classic slave
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [29:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [31:0] dat_o,
    // request channel
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [2:0]  req_len,
    output logic [3:0]  req_mask,
    output logic [31:0] req_addr,
    // write beat
    output logic        write_valid,
    output logic [31:0] write_data,
    // read beat
    input  logic        read_valid,
    input  logic [31:0] read_data,
    output logic        read_ack
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WDATA,
        RWAIT,
        ACK,
        DRAIN
    } state_t;

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so the
    // declaration stays legal when the timeout is disabled or tiny.
    localparam int unsigned      CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               req_valid_d;
    logic               write_valid_d;
    logic               read_ack_d;
    logic               ack_d;
    logic               err_d;
    logic               capture;
    logic               load_rdata;

    // Only single-beat bursts are ever issued.
    assign req_len = 3'd0;

    // Next-state and next-output decode; outputs are registered below so the
    // Wishbone and target inputs never reach an output combinationally.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d       = state;
        cnt_d         = cnt;
        req_valid_d   = 1'b0;
        write_valid_d = 1'b0;
        read_ack_d    = 1'b0;
        ack_d         = 1'b0;
        err_d         = 1'b0;
        capture       = 1'b0;
        load_rdata    = 1'b0;

        case (state)
            IDLE: begin
                if (cyc_i && stb_i) begin
                    capture     = 1'b1;
                    req_valid_d = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                // req_valid is always high here; once raised it stays up until
                // accepted regardless of what the master does with cyc_i.
                if (req_ready) begin
                    cnt_d         = '0;
                    write_valid_d = req_we;
                    state_d       = req_we ? WDATA : RWAIT;
                end else begin
                    req_valid_d = 1'b1;
                end
            end
            WDATA: begin
                ack_d   = cyc_i;
                state_d = ACK;
            end
            RWAIT: begin
                if (read_valid) begin
                    load_rdata = 1'b1;
                    read_ack_d = 1'b1;
                    ack_d      = cyc_i;
                    state_d    = ACK;
                end else if (TIMEOUT != 0) begin
                    if (cnt == CNT_MAX) begin
                        err_d   = cyc_i;
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
            end
            ACK: begin
                // Always pass through IDLE so a held strobe is not re-taken.
                state_d = IDLE;
            end
            DRAIN: begin
                // Late read beat is consumed but its data is discarded.
                if (read_valid) begin
                    read_ack_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and all output registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            cnt         <= '0;
            req_valid   <= 1'b0;
            write_valid <= 1'b0;
            read_ack    <= 1'b0;
            ack_o       <= 1'b0;
            err_o       <= 1'b0;
            req_we      <= 1'b0;
            req_mask    <= '0;
            req_addr    <= '0;
            write_data  <= '0;
            dat_o       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state       <= state_d;
            cnt         <= cnt_d;
            req_valid   <= req_valid_d;
            write_valid <= write_valid_d;
            read_ack    <= read_ack_d;
            ack_o       <= ack_d;
            err_o       <= err_d;
            if (capture) begin
                req_we     <= we_i;
                req_mask   <= sel_i;
                req_addr   <= {adr_i, 2'b00} + BASE;
                write_data <= dat_i;
            end
            if (load_rdata) begin
                dat_o <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_req_bridge.sv
// Directed bench for wb_req_bridge. Two instances share all inputs: one with a
// zero address offset and one with BASE = 32'h8000_0000, both with TIMEOUT = 4.
// A posedge monitor counts output pulses and logs request/write traffic.

module tb_wb_req_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cyc, stb, we;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        req_ready;
    logic        read_valid;
    logic [31:0] read_data;

    // instance A outputs (BASE = 0)
    logic        ack_o, err_o, req_valid, req_we, write_valid, read_ack;
    logic [31:0] dat_o, req_addr, write_data;
    logic [2:0]  req_len;
    logic [3:0]  req_mask;

    // instance B outputs (BASE = 32'h8000_0000)
    logic        ack_b, err_b, req_valid_b, req_we_b, write_valid_b, read_ack_b;
    logic [31:0] dat_b, req_addr_b, write_data_b;
    logic [2:0]  req_len_b;
    logic [3:0]  req_mask_b;

    int n_cmp = 0;
    int n_bad = 0;

    int n_req = 0, n_wv = 0, n_rack = 0, n_ack = 0, n_err = 0, n_both = 0;
    logic [31:0] wlog[$];
    logic [31:0] alog[$];

    always #5 clk = ~clk;

    wb_req_bridge #(.BASE(32'h0000_0000), .TIMEOUT(4)) u_a (
        .clk_i(clk), .rstn_i(rstn),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .sel_i(sel), .dat_i(dat),
        .ack_o(ack_o), .err_o(err_o), .dat_o(dat_o),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_len(req_len), .req_mask(req_mask), .req_addr(req_addr),
        .write_valid(write_valid), .write_data(write_data),
        .read_valid(read_valid), .read_data(read_data), .read_ack(read_ack)
    );

    wb_req_bridge #(.BASE(32'h8000_0000), .TIMEOUT(4)) u_b (
        .clk_i(clk), .rstn_i(rstn),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .sel_i(sel), .dat_i(dat),
        .ack_o(ack_b), .err_o(err_b), .dat_o(dat_b),
        .req_valid(req_valid_b), .req_ready(req_ready), .req_we(req_we_b),
        .req_len(req_len_b), .req_mask(req_mask_b), .req_addr(req_addr_b),
        .write_valid(write_valid_b), .write_data(write_data_b),
        .read_valid(read_valid), .read_data(read_data), .read_ack(read_ack_b)
    );

    // Pulse counters and traffic logs for instance A, sampled at the edge.
    always @(posedge clk) begin
        if (rstn) begin
            if (req_valid && req_ready) begin
                n_req++;
                alog.push_back(req_addr);
            end
            if (write_valid) begin
                n_wv++;
                wlog.push_back(write_data);
            end
            if (read_ack) n_rack++;
            if (ack_o)    n_ack++;
            if (err_o)    n_err++;
            if ((ack_o && err_o) || (ack_b && err_b)) n_both++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return just after the edge so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input string tag, input logic [29:0] a, input logic [31:0] d);
        bit got;
        got = 1'b0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = 4'hF; dat = d;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            if (ack_o) got = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check(tag, {31'd0, got}, 32'd1);
        tick();
    endtask

    logic [29:0] b2b_adr[3];
    logic [31:0] b2b_dat[3];
    int k, budget, base_wv, base_req, base_ack, base_w, base_a;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0;
        req_ready = 1'b0; read_valid = 1'b0; read_data = '0;
        b2b_adr[0] = 30'h011; b2b_adr[1] = 30'h022; b2b_adr[2] = 30'h033;
        b2b_dat[0] = 32'hA0A0_0001; b2b_dat[1] = 32'hB0B0_0002; b2b_dat[2] = 32'hC0C0_0003;

        // ---- reset state ----
        #3;
        check("rst_req_valid", {31'd0, req_valid}, 0);
        check("rst_ack_err", {30'd0, ack_o, err_o}, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_dat_o", dat_o, 0);
        check("rst_misc", {26'd0, req_len, req_we, write_valid, read_ack}, 0);
        tick(); tick();
        #2 rstn = 1'b1;
        tick();

        // ---- write, latency 3 edges ----
        cyc = 1; stb = 1; we = 1; adr = 30'h100; sel = 4'b0011; dat = 32'hDEADBEEF; req_ready = 1;
        tick(); // edge 1: captured
        check("wr_req_valid", {31'd0, req_valid}, 1);
        check("wr_req_addr", req_addr, 32'h0000_0400);
        check("wr_req_addr_base", req_addr_b, 32'h8000_0400);
        check("wr_req_mask", {28'd0, req_mask}, 4'b0011);
        check("wr_req_we_len", {28'd0, req_we, req_len}, 32'h8);
        check("wr_no_early_ack", {31'd0, ack_o}, 0);
        tick(); // edge 2: accepted
        check("wr_write_valid", {31'd0, write_valid}, 1);
        check("wr_write_data", write_data, 32'hDEADBEEF);
        check("wr_req_dropped", {31'd0, req_valid}, 0);
        tick(); // edge 3: ack
        check("wr_ack", {30'd0, ack_o, ack_b}, 2'b11);
        check("wr_wv_single", {31'd0, write_valid}, 0);
        cyc = 0; stb = 0; we = 0;
        tick();
        check("wr_ack_single", {31'd0, ack_o}, 0);
        check("wr_pulse_counts", {n_req[7:0], n_wv[7:0], n_ack[7:0]}, 32'h0001_0101);

        // ---- read, data two cycles after acceptance ----
        we = 0; adr = 30'h4; sel = 4'hF; cyc = 1; stb = 1;
        tick(); // edge 1
        check("rd_req_addr_base", req_addr_b, 32'h8000_0010);
        check("rd_req_addr", req_addr, 32'h0000_0010);
        check("rd_req_we", {31'd0, req_we}, 0);
        tick(); // edge 2: accepted
        check("rd_no_wv", {31'd0, write_valid}, 0);
        tick(); // edge 3: waiting
        check("rd_wait_no_ack", {30'd0, ack_o, read_ack}, 0);
        read_valid = 1; read_data = 32'h12345678;
        tick(); // edge 4: data taken
        check("rd_read_ack", {31'd0, read_ack}, 1);
        check("rd_ack", {31'd0, ack_o}, 1);
        check("rd_dat_o", dat_o, 32'h12345678);
        cyc = 0; stb = 0;
        tick();
        read_valid = 0;
        check("rd_pulses_end", {30'd0, ack_o, read_ack}, 0);
        check("rd_rack_count", n_rack, 1);

        // ---- backpressure with abandoned cycle ----
        req_ready = 0; cyc = 1; stb = 1; we = 1; adr = 30'h2A; sel = 4'hC; dat = 32'hCAFEF00D;
        tick();
        base_ack = n_ack;
        base_req = n_req;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin cyc = 0; stb = 0; end
            check("bp_req_valid", {31'd0, req_valid}, 1);
            check("bp_req_addr", req_addr, 32'h0000_00A8);
            check("bp_fields", {req_mask, 27'd0, req_we}, {4'hC, 28'd1});
            check("bp_write_data", write_data, 32'hCAFEF00D);
            tick();
        end
        check("bp_still_valid", {31'd0, req_valid}, 1);
        req_ready = 1;
        tick(); // accepted
        check("bp_write_beat", {31'd0, write_valid}, 1);
        tick();
        check("bp_no_ack", {31'd0, ack_o}, 0);
        tick();
        check("bp_accepted_once", n_req - base_req, 1);
        check("bp_ack_count", n_ack - base_ack, 0);

        // ---- read timeout ----
        base_ack = n_ack;
        cyc = 1; stb = 1; we = 0; adr = 30'h8;
        tick(); // edge 1
        tick(); // edge 2: accepted
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_no_early_err", {31'd0, err_o}, 0);
        end
        tick(); // fourth wait cycle ends
        check("to_err", {30'd0, err_o, err_b}, 2'b11);
        check("to_no_ack", {31'd0, ack_o}, 0);
        cyc = 0; stb = 0;
        tick();
        check("to_err_single", {31'd0, err_o}, 0);
        tick();
        read_valid = 1; read_data = 32'hBAD0BAD0;
        tick();
        check("to_drain_ack", {31'd0, read_ack}, 1);
        check("to_dat_kept", dat_o, 32'h12345678);
        tick();
        read_valid = 0;
        check("to_drain_single", {31'd0, read_ack}, 0);
        check("to_dat_kept2", dat_o, 32'h12345678);
        check("to_counts", {n_err[7:0], n_rack[7:0]}, 16'h0102);
        check("to_ack_count", n_ack - base_ack, 0);

        // ---- reset while in REQ ----
        req_ready = 0; cyc = 1; stb = 1; we = 1; adr = 30'h55; sel = 4'hF; dat = 32'h1111_2222;
        tick();
        check("rr_in_req", {31'd0, req_valid}, 1);
        #2 rstn = 1'b0;
        #1;
        check("rr_req_valid", {31'd0, req_valid}, 0);
        check("rr_fields", req_addr | write_data | {28'd0, req_mask}, 0);
        check("rr_dat_o", dat_o, 0);
        cyc = 0; stb = 0; req_ready = 1;
        tick();
        #2 rstn = 1'b1;
        tick();

        // ---- reset while in RWAIT ----
        cyc = 1; stb = 1; we = 0; adr = 30'h9;
        tick(); tick(); tick();
        #2 rstn = 1'b0;
        #1;
        check("rw_outputs", {28'd0, req_valid, read_ack, ack_o, err_o}, 0);
        check("rw_req_addr", req_addr_b, 0);
        cyc = 0; stb = 0;
        tick();
        #2 rstn = 1'b1;
        tick();
        wb_write("post_rst_ack", 30'h20, 32'h0BADCAFE);
        check("post_rst_wdata", wlog[$], 32'h0BADCAFE);
        check("post_rst_addr", alog[$], 32'h0000_0080);

        // ---- back-to-back writes with stb held ----
        base_wv = n_wv; base_req = n_req; base_ack = n_ack;
        base_w = wlog.size(); base_a = alog.size();
        req_ready = 1; cyc = 1; stb = 1; we = 1; sel = 4'hF;
        adr = b2b_adr[0]; dat = b2b_dat[0];
        k = 0; budget = 0;
        while (k < 3 && budget < 60) begin
            tick();
            budget++;
            if (ack_o) begin
                k++;
                if (k < 3) begin
                    adr = b2b_adr[k];
                    dat = b2b_dat[k];
                end
            end
        end
        cyc = 0; stb = 0; we = 0;
        check("b2b_acks_seen", k, 3);
        tick(); tick(); tick();
        check("b2b_req_count", n_req - base_req, 3);
        check("b2b_wv_count", n_wv - base_wv, 3);
        check("b2b_ack_count", n_ack - base_ack, 3);
        for (int i = 0; i < 3; i++) begin
            if (wlog.size() > base_w + i)
                check("b2b_wdata_order", wlog[base_w + i], b2b_dat[i]);
            else
                check("b2b_wdata_missing", 32'd0, b2b_dat[i]);
            if (alog.size() > base_a + i)
                check("b2b_addr_order", alog[base_a + i], {b2b_adr[i], 2'b00});
            else
                check("b2b_addr_missing", 32'd0, {b2b_adr[i], 2'b00});
        end

        check("ack_err_exclusive", n_both, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_req_bridge.md
WB_REQ_BRIDGE -- requirements
Module: wb_req_bridge

Interface
REQ-001 Parameter BASE, 32'h0000_0000: byte offset added to every request address.
REQ-002 Parameter TIMEOUT, 1024: read-wait cycle limit before err_o; 0 disables the timeout.
REQ-003 clk_i  in  1  single system clock; every register samples on the rising edge.
REQ-004 rstn_i  in  1  asynchronous, active-low reset.
REQ-005 cyc_i, stb_i, we_i  in  1 each  Wishbone classic slave cycle, strobe and write enable.
REQ-006 adr_i  in  30  Wishbone word address.
REQ-007 sel_i  in  4  byte lane selects.
REQ-008 dat_i  in  32  write data.
REQ-009 ack_o, err_o  out  1 each  Wishbone termination.
REQ-010 dat_o  out  32  read data.
REQ-011 req_valid  out  1; req_ready  in  1  request handshake.
REQ-012 req_we  out  1  write request.
REQ-013 req_len  out  3  burst length code; always 3'd0 (single beat).
REQ-014 req_mask  out  4  byte mask.
REQ-015 req_addr  out  32  byte address.
REQ-016 write_valid  out  1  write beat strobe; write_data  out  32  write beat data.
REQ-017 read_valid  in  1  read beat available; read_data  in  32  read beat data; read_ack  out  1  read beat consumed.

Function
REQ-018 Every output SHALL be a register; there are no combinational input-to-output paths.
REQ-019 The FSM SHALL have the states IDLE, REQ, WDATA, RWAIT, ACK and DRAIN.
REQ-020 IDLE: when cyc_i & stb_i are sampled high, the block SHALL capture the following and go to REQ:
- req_addr = {adr_i,2'b00} + BASE (mod 2^32)
- req_mask = sel_i
- req_we = we_i
- write_data = dat_i
REQ-021 REQ: req_valid=1; the request fields SHALL stay stable until req_valid & req_ready are sampled high, then the FSM goes to WDATA if req_we, else RWAIT.
REQ-022 Once req_valid is asserted, it SHALL NOT deassert before acceptance, even if cyc_i drops.
REQ-023 WDATA: write_valid=1 for exactly one cycle, then ACK.
- The target does not backpressure write beats.
REQ-024 RWAIT: on read_valid sampled high, the block SHALL do the following on the same edge, then go to ACK:
- dat_o <= read_data
- read_ack <= 1 (high for exactly one cycle)
REQ-025 The target SHALL hold read_valid until it samples read_ack; the bridge SHALL ignore read_valid in every state other than RWAIT and DRAIN.
REQ-026 ACK: ack_o=1 for exactly one cycle if cyc_i is high, then IDLE; if cyc_i is low, ack_o stays 0 (abandoned cycle, result discarded).
REQ-027 RWAIT timeout: a counter SHALL count cycles spent in RWAIT.
- When the count reaches TIMEOUT, err_o=1 for one cycle (gated by cyc_i) and the FSM goes to DRAIN.
- With TIMEOUT=0 the block waits indefinitely.
REQ-028 DRAIN: the bridge SHALL wait for read_valid, then pulse read_ack once without updating dat_o, then go to IDLE.
REQ-029 ack_o and err_o SHALL never be high together; at most one termination is issued per Wishbone cycle.
REQ-030 Minimum latency with req_ready=1 and read_valid returned in the acceptance cycle:
- strobe sampled at edge 1 -> ack_o high after edge 3, for both reads and writes.
REQ-031 Zero-wait simultaneous events: req_ready already high on REQ entry SHALL be accepted at the first REQ edge.
REQ-032 cyc_i is ignored outside IDLE except for gating ack_o/err_o.
REQ-033 IDLE SHALL not re-trigger on the strobe being terminated: ACK always passes through IDLE, and a master holding stb_i for a new cycle starts that new cycle.

Reset
REQ-034 On rstn_i low, asynchronously:
- state = IDLE
- req_valid, write_valid, read_ack, ack_o, err_o = 0
- req_addr, req_mask, write_data, dat_o = 0; req_we = 0; req_len = 0
- timeout counter = 0
REQ-035 A reset mid-transaction SHALL abandon it immediately; both sides are required to reset together.

Verification
REQ-036 Write, BASE=0, req_ready=1: adr_i=30'h100, sel_i=4'b0011, dat_i=32'hDEADBEEF ->
- req_addr=32'h400, req_mask=4'b0011, req_we=1
- one write_valid with write_data=32'hDEADBEEF
- ack_o high after edge 3
REQ-037 Read, BASE=32'h8000_0000: adr_i=30'h4; target returns read_valid two cycles after acceptance with 32'h12345678 ->
- req_addr=32'h8000_0010
- one read_ack pulse
- dat_o=32'h12345678 with ack_o
REQ-038 Backpressure: req_ready held low 5 cycles while cyc_i drops after 2 -> req_valid and fields stable throughout; request accepted; no ack_o issued; FSM returns to IDLE.
REQ-039 Timeout, TIMEOUT=4: read accepted, read_valid withheld -> err_o after 4 RWAIT cycles; a later read_valid gets one read_ack; dat_o unchanged.
REQ-040 Reset: rstn_i asserted while in REQ and while in RWAIT -> all outputs 0 immediately; the next transaction completes normally.
REQ-041 Back-to-back: master holds stb_i across 3 consecutive writes -> exactly 3 requests, 3 write_valid pulses and 3 ack_o pulses, in order.
